// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types, constants and BCD/seconds helpers for the mm:ss timer.
// Revision: 1.0
`default_nettype none

package bcd_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_PAUSED = 3'd2,
    ST_ADJUST = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_MAX_H = 4'd5;
  localparam bcd_t DIG_MAX   = 4'd9;

  // Total seconds of a {min_h,min_l,sec_h,sec_l} count; 99:59 fits in 13 bits.
  function automatic logic [12:0] dig_to_secs(input logic [15:0] d);
    return 13'(d[15:12]) * 13'd600 + 13'(d[11:8]) * 13'd60
         + 13'(d[7:4]) * 13'd10 + 13'(d[3:0]);
  endfunction

  function automatic logic [15:0] secs_to_dig(input logic [12:0] s);
    logic [6:0] m;
    logic [5:0] ss;
    m  = 7'(s / 13'd60);
    ss = 6'(s % 13'd60);
    return {4'(m / 7'd10), 4'(m % 7'd10), 4'(ss / 6'd10), 4'(ss % 6'd10)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_timer_core_counter.sv
// bcd_mod_counter: two-digit BCD modulo-(MAX+1) counter with load, carry and borrow.
// Revision: 1.0
`default_nettype none

module bcd_mod_counter
  import bcd_timer_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic       carry,
  output logic       borrow
);

  localparam bcd_t MAX_H = 4'(MAX / 10);
  localparam bcd_t MAX_L = 4'(MAX % 10);

  bcd_t hi, lo;
  logic up, dn, at_max, at_zero;

  assign up      = inc & ~dec & ~load;
  assign dn      = dec & ~inc & ~load;
  assign at_max  = (hi == MAX_H) && (lo == MAX_L);
  assign at_zero = (hi == 4'd0) && (lo == 4'd0);
  assign carry   = up & at_max;
  assign borrow  = dn & at_zero;
  assign val     = {hi, lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 4'd0;
      lo <= 4'd0;
    end else if (load) begin
      hi <= load_val[7:4];
      lo <= load_val[3:0];
    end else if (up) begin
      if (at_max) begin
        hi <= 4'd0;
        lo <= 4'd0;
      end else if (lo == DIG_MAX) begin
        hi <= hi + 4'd1;
        lo <= 4'd0;
      end else begin
        lo <= lo + 4'd1;
      end
    end else if (dn) begin
      if (at_zero) begin
        hi <= MAX_H;
        lo <= MAX_L;
      end else if (lo == 4'd0) begin
        hi <= hi - 4'd1;
        lo <= DIG_MAX;
      end else begin
        lo <= lo - 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_timer_core.sv
// bcd_timer_core: mm:ss BCD stopwatch core with run/pause/adjust/done FSM and lap hold.
// Revision: 1.0
`default_nettype none

module bcd_timer_core
  import bcd_timer_pkg::*;
#(
  parameter int MAX_MIN   = 59,
  parameter int FAST_STEP = 2,
  parameter bit WRAP      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        tick_fast,
  input  logic        start_stop,
  input  logic        cnt_dn,
  input  logic        adj,
  input  logic        adj_sel,
  input  logic        adj_fast,
  input  logic        inc,
  input  logic        dec,
  input  logic        lap,
  input  logic        clr,
  output logic [15:0] dig,
  output logic [15:0] disp,
  output logic [2:0]  state_o,
  output logic        done,
  output logic        frozen
);

  localparam logic [7:0]  MIN_TOP    = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0]  SEC_TOP    = {SEC_MAX_H, DIG_MAX};
  localparam logic [15:0] TERM_UP    = {MIN_TOP, SEC_TOP};
  localparam logic [15:0] TERM_UP_M1 = {MIN_TOP, SEC_MAX_H, DIG_MAX - 4'd1};
  localparam logic [12:0] TOTAL_MAX  = 13'(MAX_MIN * 60 + 59);

  state_t      st, st_nxt;
  logic [7:0]  sec_v, min_v, sec_ld, min_ld;
  logic        run_tick, zero, fast_load, field_en, cnt_load;
  logic        sec_inc, sec_dec, min_inc, min_dec;
  logic        sec_carry, sec_borrow, min_carry, min_borrow;
  logic        at_term, will_hit;
  logic [12:0] fast_sum;
  logic [15:0] fast_dig, hold;

  assign dig      = {min_v, sec_v};
  assign state_o  = st;
  assign at_term  = cnt_dn ? (dig == 16'h0000) : (dig == TERM_UP);
  assign will_hit = cnt_dn ? (dig == 16'h0001) : (dig == TERM_UP_M1);

  // Fast-advance works on the whole count in seconds so carry and saturation are exact.
  assign fast_sum = dig_to_secs(dig) + 13'(FAST_STEP);
  assign fast_dig = (fast_sum > TOTAL_MAX) ? TERM_UP : secs_to_dig(fast_sum);

  always_comb begin
    st_nxt    = st;
    run_tick  = 1'b0;
    zero      = 1'b0;
    fast_load = 1'b0;
    field_en  = 1'b0;
    if (adj && st != ST_ADJUST) begin
      st_nxt = ST_ADJUST;
    end else begin
      case (st)
        ST_IDLE: begin
          if (clr) zero = 1'b1;
          else if (start_stop) st_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (start_stop) begin
            st_nxt = ST_PAUSED;
          end else if (tick_1hz) begin
            if (at_term && !WRAP) begin
              st_nxt = ST_DONE;
            end else begin
              run_tick = 1'b1;
              if (will_hit && !WRAP) st_nxt = ST_DONE;
            end
          end
        end
        ST_PAUSED: begin
          if (clr) begin
            zero   = 1'b1;
            st_nxt = ST_IDLE;
          end else if (start_stop) begin
            st_nxt = ST_RUN;
          end
        end
        ST_ADJUST: begin
          if (!adj) st_nxt = (dig == 16'h0000) ? ST_IDLE : ST_PAUSED;
          else if (adj_fast) fast_load = tick_fast;
          else field_en = inc ^ dec;
        end
        ST_DONE: begin
          if (clr) begin
            zero   = 1'b1;
            st_nxt = ST_IDLE;
          end
        end
        default: st_nxt = ST_IDLE;
      endcase
    end
  end

  // Minutes follow the seconds carry only while running; field adjust keeps them independent.
  assign sec_inc  = (run_tick & ~cnt_dn) | (field_en & adj_sel & inc);
  assign sec_dec  = (run_tick & cnt_dn) | (field_en & adj_sel & dec);
  assign min_inc  = run_tick ? sec_carry : (field_en & ~adj_sel & inc);
  assign min_dec  = run_tick ? sec_borrow : (field_en & ~adj_sel & dec);
  assign cnt_load = zero | fast_load;
  assign sec_ld   = fast_load ? fast_dig[7:0] : 8'h00;
  assign min_ld   = fast_load ? fast_dig[15:8] : 8'h00;

  bcd_mod_counter #(.MAX(59)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_inc),
    .dec      (sec_dec),
    .load     (cnt_load),
    .load_val (sec_ld),
    .val      (sec_v),
    .carry    (sec_carry),
    .borrow   (sec_borrow)
  );

  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_inc),
    .dec      (min_dec),
    .load     (cnt_load),
    .load_val (min_ld),
    .val      (min_v),
    .carry    (min_carry),
    .borrow   (min_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      done   <= 1'b0;
      frozen <= 1'b0;
      hold   <= 16'h0000;
      disp   <= 16'h0000;
    end else begin
      st   <= st_nxt;
      done <= (st_nxt == ST_DONE) && (st != ST_DONE);
      disp <= frozen ? hold : dig;
      if (lap && !frozen) hold <= dig;
      if (zero) frozen <= 1'b0;
      else if (lap) frozen <= ~frozen;
    end
  end

endmodule

`default_nettype wire

// File: doc/bcd_timer_core.md
Name: bcd_timer_core

Overview:
Parametrised mm:ss BCD timer core for the stopwatch datapath: counts up or down on a 1 Hz enable and supports pause, field adjust, fast-advance and lap/split capture. It replaces free-form per-digit counting with an explicit mode FSM, a single clock domain and tick enables, so no derived clocks are used as data. It sits between the clock-enable divider and the 7-segment display mux.

Parameters:
MAX_MIN, 59, upper minute value (1..99); the count range is 00:00..MAX_MIN:59.
FAST_STEP, 2, seconds added per tick_fast while in fast-advance (1..9).
WRAP, 0, 0 = stop at the terminal value and enter DONE; 1 = wrap around and stay in RUN.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick_1hz  in  1  one-cycle count enable
tick_fast  in  1  one-cycle fast-advance enable (2 Hz)
start_stop  in  1  one-cycle pulse; toggles RUN/PAUSED
cnt_dn  in  1  level; 1 = count down, 0 = count up
adj  in  1  level; 1 = adjust mode
adj_sel  in  1  0 = minutes field, 1 = seconds field
adj_fast  in  1  level; while in ADJUST, advance by FAST_STEP on tick_fast
inc  in  1  one-cycle pulse; increment the selected field
dec  in  1  one-cycle pulse; decrement the selected field
lap  in  1  one-cycle pulse; toggles display freeze
clr  in  1  one-cycle pulse; zero the count (only accepted in IDLE, PAUSED or DONE)
dig  out  16  live count {min_h,min_l,sec_h,sec_l}
disp  out  16  display value: live count, or the held lap value while frozen
state_o  out  3  current FSM state
done  out  1  one-cycle pulse on entry to DONE
frozen  out  1  lap hold active

Behaviour:
- Reset:
  - dig=0, disp=0, state=IDLE, done=0, frozen=0.
  - rst has priority over every other input in the same cycle.
- FSM states: IDLE, RUN, PAUSED, ADJUST, DONE.
- ADJUST entry and exit:
  - adj=1 forces ADJUST from any state on the next clock.
  - adj=0 in ADJUST returns to PAUSED, or to IDLE if the count is 00:00.
- Transitions in other states:
  - IDLE: start_stop goes to RUN.
  - RUN: start_stop goes to PAUSED. Reaching the terminal value with WRAP=0 goes to DONE.
  - PAUSED: start_stop goes to RUN. clr zeroes the count and goes to IDLE.
  - DONE: start_stop is ignored. clr zeroes the count and goes to IDLE.
- Terminal value and wrap:
  - Terminal value is MAX_MIN:59 when counting up and 00:00 when counting down.
  - When counting down from 00:00, RUN goes straight to DONE with no count.
  - WRAP=1: up-count MAX_MIN:59 wraps to 00:00; down-count 00:00 wraps to MAX_MIN:59. DONE is never entered.
- RUN counting:
  - On a tick_1hz cycle, the count changes by ±1 second with BCD carry or borrow: sec_l 9→0 carries into sec_h; sec_h 5→0 carries into minutes; minutes carry into min_h.
  - Latency: dig updates on the clock edge of the tick cycle.
  - On the terminal transition with WRAP=0, dig holds the terminal value and done pulses on the same edge that state becomes DONE.
- ADJUST, inc/dec:
  - inc or dec changes only the selected field. Seconds wrap 59↔00 with no carry into minutes. Minutes wrap MAX_MIN↔00.
  - inc and dec asserted together: no change.
- ADJUST, fast-advance:
  - adj_fast=1 with tick_fast adds FAST_STEP seconds to the full count, with carry into minutes.
  - Saturates at MAX_MIN:59; never wraps.
  - inc/dec pulses are ignored while adj_fast=1.
- Inputs ignored per state:
  - tick_1hz is ignored outside RUN.
  - cnt_dn changes take effect at the next tick.
  - clr in RUN or ADJUST is ignored.
- Lap:
  - A lap pulse while frozen=0 captures dig into the hold register and sets frozen=1.
  - The next lap pulse clears frozen.
  - disp = frozen ? hold : dig, registered, so disp lags dig by one cycle.
  - clr or rst clears frozen.
- Digit invariant: dig always holds valid BCD (every nibble 0..9, sec_h ≤ 5) and never exceeds MAX_MIN:59.

Decomposition:
- Package bcd_timer_pkg:
  - state enum with encodings IDLE=0, RUN=1, PAUSED=2, ADJUST=3, DONE=4;
  - bcd_t (4-bit digit type);
  - constants SEC_MAX_H=5 and DIG_MAX=9.
- Sub-module bcd_mod_counter:
  - a two-digit BCD counter with parameter MAX;
  - inc, dec and load inputs;
  - carry and borrow outputs.
- bcd_timer_core instantiates bcd_mod_counter twice: seconds (MAX=59) and minutes (MAX=MAX_MIN).

Test Plan:
- Up-count at MAX_MIN=59, WRAP=0: rst, start_stop, 60 ticks → dig=0x0100. From 59:58, 2 ticks → dig=0x5959, state=DONE, done pulses once; further ticks leave dig unchanged.
- Down-count: load 01:00 via ADJUST, cnt_dn=1, start_stop, 1 tick → dig=0x0059. 59 more ticks → dig=0x0000, DONE.
- Field adjust with MAX_MIN=15, adj=1, adj_sel=0 at 15:xx: inc → minutes=00; dec → 15. With adj_sel=1 at 00:59: inc → 00:00, and minutes are unchanged.
- Fast-advance with FAST_STEP=2 from 00:58: one tick_fast → 01:00. From 59:58: one tick_fast → 59:59, then saturates.
- Lap: in RUN at 00:10, lap → disp holds 0x0010 while dig keeps counting to 00:15. A second lap → disp=0x0015 one cycle later.
- WRAP=1, cnt_dn=1 at 00:00 in RUN: one tick → dig=0x5959, state stays RUN, done=0. rst mid-run → all outputs zero on the next edge.
